// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory request/grant/response bus
//   req    : fetch stage requests a word read at addr
//   addr   : word-aligned read address
//   gnt    : memory accepts the request this cycle
//   rvalid : read data valid, at least one cycle after gnt
//   rdata  : returned instruction word
interface instr_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: one-outstanding-read fetch stage with a small output FIFO toward decode
//   clk, rst          : clock and asynchronous active-low reset
//   pc_in, pc_valid   : fetch candidate from the PC register
//   pc_ready          : address consumed this cycle
//   redirect          : taken branch/jump, flushes all unconsumed work
//   imem              : instruction memory bus (master side)
//   if_valid/if_ready : head-of-FIFO handshake toward decode
//   if_instr, if_pc   : head instruction and its PC
//   if_misalign       : head was produced for a misaligned address
module instr_fetch #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          pc_in,
    input  logic                 pc_valid,
    output logic                 pc_ready,
    input  logic                 redirect,
    instr_fetch_if.master        imem,
    output logic                 if_valid,
    input  logic                 if_ready,
    output logic [31:0]          if_instr,
    output logic [31:0]          if_pc,
    output logic                 if_misalign
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  count;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [31:0]    pend_pc;
    logic [31:0]    fifo_instr [DEPTH];
    logic [31:0]    fifo_pc    [DEPTH];
    logic           fifo_mis   [DEPTH];
    logic           issue_ok, mis_push, resp_push, push, pop;

    // Space is checked only in IDLE (nothing outstanding), so a granted
    // request always has a free slot waiting for its response.
    assign issue_ok  = rst && pc_valid && state == IDLE && count < CW'(DEPTH) && !redirect;
    assign push      = mis_push || resp_push;
    assign pop       = if_valid && if_ready && !redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (imem.req && imem.gnt) ? WAIT : IDLE;
            // A redirect racing the response simply discards that response.
            WAIT:    state_nx = imem.rvalid ? IDLE : (redirect ? DROP : WAIT);
            DROP:    state_nx = imem.rvalid ? IDLE : DROP;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        imem.addr = pc_in;
        imem.req  = issue_ok && pc_in[1:0] == 2'b00;
        mis_push  = issue_ok && pc_in[1:0] != 2'b00;
        pc_ready  = (imem.req && imem.gnt) || mis_push;
        resp_push = state == WAIT && imem.rvalid && !redirect;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pend_pc <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_instr[i] <= '0;
                fifo_pc[i]    <= '0;
                fifo_mis[i]   <= 1'b0;
            end
        end else begin
            if (imem.req && imem.gnt) pend_pc <= pc_in;
            if (redirect) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                count <= count + CW'(push) - CW'(pop);
                if (push) begin
                    fifo_instr[wr_ptr] <= resp_push ? imem.rdata : NOP_INSTR;
                    fifo_pc[wr_ptr]    <= resp_push ? pend_pc : pc_in;
                    fifo_mis[wr_ptr]   <= !resp_push;
                    wr_ptr             <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    assign if_valid    = count != '0;
    assign if_instr    = fifo_instr[rd_ptr];
    assign if_pc       = fifo_pc[rd_ptr];
    assign if_misalign = fifo_mis[rd_ptr];
endmodule
